// File: rtl/rgb_led_sched.sv
// Touch-driven RGB LED scheduler: debounced red/blue requests fade their colour in and out, heartbeat on green when idle.
// PWM outputs are registered one cycle after the level; there is no preemption, and a non-owner request waits until the owner's level returns to 0.
module rgb_led_sched #(
   parameter int unsigned DEBOUNCE_LOG2  = 16,
   parameter int unsigned FADE_STEP_LOG2 = 12,
   parameter int unsigned HB_LOG2        = 24
) (
   input  logic       clki,
   input  logic       rst_n,
   input  logic       touch_1,
   input  logic       touch_3,
   output logic       pwm_r,
   output logic       pwm_g,
   output logic       pwm_b,
   output logic       led_en,
   output logic [1:0] active_src
);

   localparam int unsigned DW = (DEBOUNCE_LOG2  > 0) ? DEBOUNCE_LOG2  : 1;
   localparam int unsigned SW = (FADE_STEP_LOG2 > 0) ? FADE_STEP_LOG2 : 1;
   localparam int unsigned HW = (HB_LOG2        > 0) ? HB_LOG2        : 1;

   localparam logic [DW-1:0] DB_MAX   = DW'((64'd1 << DEBOUNCE_LOG2) - 64'd1);
   localparam logic [SW-1:0] STEP_MAX = SW'((64'd1 << FADE_STEP_LOG2) - 64'd1);

   localparam logic [1:0] SRC_HB   = 2'd0;
   localparam logic [1:0] SRC_BLUE = 2'd1;
   localparam logic [1:0] SRC_RED  = 2'd2;

   typedef enum logic [1:0] {
      HB       = 2'd0,
      FADE_IN  = 2'd1,
      HOLD     = 2'd2,
      FADE_OUT = 2'd3
   } state_t;

   // index 0 = blue (touch_1), index 1 = red (touch_3)
   logic [1:0]    sync1;
   logic [1:0]    sync2;
   logic [1:0]    flag;
   logic [DW-1:0] db_cnt [2];

   logic [SW-1:0] step_cnt;
   logic          tick;
   logic [HW-1:0] hb_cnt;
   logic [7:0]    pwm_cnt;

   state_t        state;
   state_t        state_nxt;
   logic [1:0]    src_nxt;
   logic [7:0]    level;
   logic [7:0]    level_nxt;
   logic          own_pressed;

   always_ff @(posedge clki) begin
      if (!rst_n) begin
         sync1     <= 2'b11;
         sync2     <= 2'b11;
         flag      <= 2'b00;
         db_cnt[0] <= '0;
         db_cnt[1] <= '0;
      end else begin
         sync1 <= {touch_3, touch_1};
         sync2 <= sync1;
         for (int i = 0; i < 2; i++) begin
            // flag is active-high "pressed"; the synchronized input is active-low
            if (~sync2[i] == flag[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_MAX) begin
               flag[i]   <= ~flag[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DW'(1);
            end
         end
      end
   end

   assign tick = (step_cnt == STEP_MAX);

   always_ff @(posedge clki) begin
      if (!rst_n) begin
         step_cnt <= '0;
         hb_cnt   <= '0;
         pwm_cnt  <= '0;
      end else begin
         step_cnt <= tick ? '0 : step_cnt + SW'(1);
         hb_cnt   <= hb_cnt + HW'(1);
         pwm_cnt  <= pwm_cnt + 8'd1;
      end
   end

   assign own_pressed = (active_src == SRC_RED) ? flag[1] : flag[0];

   always_ff @(posedge clki) begin
      if (!rst_n) begin
         state      <= HB;
         active_src <= SRC_HB;
         level      <= 8'd0;
      end else begin
         state      <= state_nxt;
         active_src <= src_nxt;
         level      <= level_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      src_nxt   = active_src;
      level_nxt = level;
      case (state)
         HB: begin
            level_nxt = 8'd0;
            src_nxt   = SRC_HB;
            if (flag[1]) begin
               state_nxt = FADE_IN;
               src_nxt   = SRC_RED;
            end else if (flag[0]) begin
               state_nxt = FADE_IN;
               src_nxt   = SRC_BLUE;
            end
         end
         FADE_IN: begin
            if (!own_pressed) begin
               state_nxt = FADE_OUT;
            end else if (level == 8'hFF) begin
               state_nxt = HOLD;
            end else if (tick) begin
               level_nxt = level + 8'd1;
               if (level == 8'hFE) state_nxt = HOLD;
            end
         end
         HOLD: begin
            level_nxt = 8'hFF;
            if (!own_pressed) state_nxt = FADE_OUT;
         end
         FADE_OUT: begin
            if (own_pressed) begin
               state_nxt = FADE_IN;
            end else if (level == 8'd0 || (tick && level == 8'd1)) begin
               // owner is released here, so any set flag belongs to the waiting source
               level_nxt = 8'd0;
               if (flag[1]) begin
                  state_nxt = FADE_IN;
                  src_nxt   = SRC_RED;
               end else if (flag[0]) begin
                  state_nxt = FADE_IN;
                  src_nxt   = SRC_BLUE;
               end else begin
                  state_nxt = HB;
                  src_nxt   = SRC_HB;
               end
            end else if (tick) begin
               level_nxt = level - 8'd1;
            end
         end
         default: begin
            state_nxt = HB;
            src_nxt   = SRC_HB;
            level_nxt = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clki) begin
      if (!rst_n) begin
         pwm_r  <= 1'b0;
         pwm_g  <= 1'b0;
         pwm_b  <= 1'b0;
         led_en <= 1'b0;
      end else begin
         pwm_r  <= (state != HB) && (active_src == SRC_RED)  && (pwm_cnt < level);
         pwm_b  <= (state != HB) && (active_src == SRC_BLUE) && (pwm_cnt < level);
         pwm_g  <= (state == HB) && hb_cnt[HW-1];
         led_en <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rgb_led_sched.sv
// Self-checking bench for rgb_led_sched with short debounce, per-cycle fade steps and a 16-cycle heartbeat.
module tb_rgb_led_sched;

   logic       clki = 1'b0;
   logic       rst_n = 1'b0;
   logic       touch_1 = 1'b1;
   logic       touch_3 = 1'b1;
   logic       pwm_r, pwm_g, pwm_b, led_en;
   logic [1:0] active_src;

   int checks = 0;
   int errors = 0;
   int onehot_viol = 0;
   logic [1:0] exp_src_q [$];

   rgb_led_sched #(.DEBOUNCE_LOG2(2), .FADE_STEP_LOG2(0), .HB_LOG2(4)) dut (
      .clki(clki), .rst_n(rst_n), .touch_1(touch_1), .touch_3(touch_3),
      .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b), .led_en(led_en),
      .active_src(active_src)
   );

   always #5 clki = ~clki;

   always @(negedge clki)
      if (int'(pwm_r) + int'(pwm_g) + int'(pwm_b) > 1) onehot_viol++;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clki);
   endtask

   task automatic wait_src_change(input int budget, output logic [1:0] val, output int n,
                                  output bit timeout, output int b_high);
      logic [1:0] prev;
      prev = active_src; val = prev; n = 0; timeout = 1'b1; b_high = 0;
      for (int i = 1; i <= budget; i++) begin
         @(negedge clki);
         if (pwm_b) b_high++;
         if (active_src !== prev) begin
            val = active_src; n = i; timeout = 1'b0;
            break;
         end
      end
   endtask

   task automatic wait_level(input logic [7:0] tgt, input int budget, output bit timeout);
      timeout = 1'b1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clki);
         if (dut.level == tgt) begin timeout = 1'b0; break; end
      end
   endtask

   task automatic wait_state(input logic [1:0] tgt, input int budget, output bit timeout);
      timeout = 1'b1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clki);
         if (dut.state == tgt) begin timeout = 1'b0; break; end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; touch_1 = 1'b1; touch_3 = 1'b1;
      cyc(3);
      checks++;
      if ({pwm_r, pwm_g, pwm_b, led_en, active_src} !== 6'b0) begin
         errors++;
         $display("FAIL reset_outputs got %b expected 000000", {pwm_r, pwm_g, pwm_b, led_en, active_src});
      end
      checks++;
      if (dut.level !== 8'd0) begin
         errors++; $display("FAIL reset_level got %0d expected 0", dut.level);
      end
      rst_n = 1'b1;
      cyc(1);
      checks++;
      if (led_en !== 1'b1) begin
         errors++; $display("FAIL led_en_after_reset got %b expected 1", led_en);
      end
   endtask

   task automatic test_heartbeat();
      logic prev_g;
      int last = -1;
      int trans = 0;
      int bad = 0;
      prev_g = pwm_g;
      for (int i = 0; i < 48; i++) begin
         cyc(1);
         if (pwm_r || pwm_b || active_src != 2'd0) bad++;
         if (pwm_g !== prev_g) begin
            if (last >= 0) begin
               checks++;
               if (i - last != 8) begin
                  errors++; $display("FAIL hb_interval got %0d expected 8", i - last);
               end
            end
            last = i; trans++; prev_g = pwm_g;
         end
      end
      checks++;
      if (trans < 5) begin
         errors++; $display("FAIL hb_transitions got %0d expected >= 5", trans);
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL hb_idle_outputs got %0d bad cycles expected 0", bad);
      end
   endtask

   task automatic test_glitch();
      logic [1:0] seen = 2'd0;
      logic [1:0] e;
      exp_src_q.push_back(2'd0);
      touch_1 = 1'b0;
      cyc(3);
      touch_1 = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         seen = seen | active_src;
      end
      e = exp_src_q.pop_front();
      checks++;
      if (seen !== e) begin
         errors++; $display("FAIL glitch_no_grant got %0d expected %0d", seen, e);
      end
   endtask

   task automatic test_fade_in();
      logic [1:0] v, e;
      int n, bh, cnt_b, cnt_rg;
      bit to;
      touch_1 = 1'b0;
      exp_src_q.push_back(2'd1);
      wait_src_change(20, v, n, to, bh);
      e = exp_src_q.pop_front();
      checks++;
      if (to || v !== e) begin
         errors++; $display("FAIL blue_grant got %0d expected %0d (timeout %0d)", v, e, to);
      end
      checks++;
      if (n > 7) begin
         errors++; $display("FAIL grant_latency got %0d expected <= 7", n);
      end
      checks++;
      if (dut.level !== 8'd0 || dut.state !== 2'd1) begin
         errors++; $display("FAIL fade_in_start got level %0d state %0d expected 0 1", dut.level, dut.state);
      end
      cyc(254);
      checks++;
      if (dut.level !== 8'd254) begin
         errors++; $display("FAIL level_254 got %0d expected 254", dut.level);
      end
      cyc(1);
      checks++;
      if (dut.level !== 8'd255 || dut.state !== 2'd2) begin
         errors++; $display("FAIL level_255_hold got level %0d state %0d expected 255 2", dut.level, dut.state);
      end
      cyc(2);
      cnt_b = 0; cnt_rg = 0;
      for (int i = 0; i < 256; i++) begin
         cyc(1);
         if (pwm_b) cnt_b++;
         if (pwm_r || pwm_g) cnt_rg++;
      end
      checks++;
      if (cnt_b != 255) begin
         errors++; $display("FAIL hold_duty_b got %0d expected 255", cnt_b);
      end
      checks++;
      if (cnt_rg != 0) begin
         errors++; $display("FAIL hold_other_colours got %0d expected 0", cnt_rg);
      end
      touch_1 = 1'b1;
      exp_src_q.push_back(2'd0);
      wait_src_change(400, v, n, to, bh);
      e = exp_src_q.pop_front();
      checks++;
      if (to || v !== e) begin
         errors++; $display("FAIL blue_back_to_hb got %0d expected %0d (timeout %0d)", v, e, to);
      end
   endtask

   task automatic test_priority();
      logic [1:0] v, e;
      int n, bh, b_total;
      bit to;
      touch_1 = 1'b0; touch_3 = 1'b0;
      exp_src_q.push_back(2'd2);
      wait_src_change(20, v, n, to, bh);
      e = exp_src_q.pop_front();
      checks++;
      if (to || v !== e) begin
         errors++; $display("FAIL red_priority got %0d expected %0d (timeout %0d)", v, e, to);
      end
      b_total = 0;
      for (int i = 0; i < 300 && dut.level != 8'd255; i++) begin
         cyc(1);
         if (pwm_b) b_total++;
      end
      touch_3 = 1'b1;
      exp_src_q.push_back(2'd1);
      wait_src_change(400, v, n, to, bh);
      b_total += bh;
      e = exp_src_q.pop_front();
      checks++;
      if (to || v !== e) begin
         errors++; $display("FAIL red_to_blue_direct got %0d expected %0d (timeout %0d)", v, e, to);
      end
      checks++;
      if (dut.level !== 8'd0) begin
         errors++; $display("FAIL handover_level got %0d expected 0", dut.level);
      end
      checks++;
      if (b_total != 0) begin
         errors++; $display("FAIL pwm_b_under_red got %0d high cycles expected 0", b_total);
      end
      touch_1 = 1'b1;
      exp_src_q.push_back(2'd0);
      wait_src_change(400, v, n, to, bh);
      e = exp_src_q.pop_front();
      checks++;
      if (to || v !== e) begin
         errors++; $display("FAIL priority_back_to_hb got %0d expected %0d (timeout %0d)", v, e, to);
      end
   endtask

   task automatic test_release_repress();
      logic [1:0] v, e;
      int n, bh;
      bit to;
      touch_1 = 1'b0;
      exp_src_q.push_back(2'd1);
      wait_src_change(20, v, n, to, bh);
      e = exp_src_q.pop_front();
      checks++;
      if (to || v !== e) begin
         errors++; $display("FAIL repress_grant got %0d expected %0d (timeout %0d)", v, e, to);
      end
      // six cycles of sync + debounce elapse before the release is seen
      wait_level(8'd94, 300, to);
      touch_1 = 1'b1;
      if (!to) wait_state(2'd3, 20, to);
      checks++;
      if (to || dut.level !== 8'd100) begin
         errors++; $display("FAIL fade_out_from_100 got %0d expected 100 (timeout %0d)", dut.level, to);
      end
      wait_level(8'd46, 300, to);
      touch_1 = 1'b0;
      if (!to) wait_state(2'd1, 20, to);
      checks++;
      if (to || dut.level !== 8'd40) begin
         errors++; $display("FAIL fade_in_from_40 got %0d expected 40 (timeout %0d)", dut.level, to);
      end
      cyc(1);
      checks++;
      if (dut.level !== 8'd41) begin
         errors++; $display("FAIL fade_in_resumes got %0d expected 41", dut.level);
      end
      touch_1 = 1'b1;
      exp_src_q.push_back(2'd0);
      wait_src_change(400, v, n, to, bh);
      e = exp_src_q.pop_front();
      checks++;
      if (to || v !== e) begin
         errors++; $display("FAIL repress_back_to_hb got %0d expected %0d (timeout %0d)", v, e, to);
      end
   endtask

   task automatic test_reset_in_hold();
      logic [1:0] v, e;
      int n, bh;
      bit to;
      touch_1 = 1'b0;
      exp_src_q.push_back(2'd1);
      wait_src_change(20, v, n, to, bh);
      e = exp_src_q.pop_front();
      checks++;
      if (to || v !== e) begin
         errors++; $display("FAIL hold_grant got %0d expected %0d (timeout %0d)", v, e, to);
      end
      wait_state(2'd2, 300, to);
      checks++;
      if (to) begin
         errors++; $display("FAIL reach_hold got timeout expected HOLD");
      end
      rst_n = 1'b0;
      cyc(1);
      rst_n = 1'b1;
      checks++;
      if ({pwm_r, pwm_g, pwm_b, led_en, active_src} !== 6'b0) begin
         errors++;
         $display("FAIL midhold_reset_outputs got %b expected 000000", {pwm_r, pwm_g, pwm_b, led_en, active_src});
      end
      checks++;
      if (dut.level !== 8'd0 || dut.state !== 2'd0) begin
         errors++; $display("FAIL midhold_reset_fsm got level %0d state %0d expected 0 0", dut.level, dut.state);
      end
      cyc(6);
      checks++;
      if (active_src !== 2'd0) begin
         errors++; $display("FAIL early_regrant got %0d expected 0", active_src);
      end
      checks++;
      if (led_en !== 1'b1) begin
         errors++; $display("FAIL led_en_after_midhold_reset got %b expected 1", led_en);
      end
      cyc(1);
      checks++;
      if (active_src !== 2'd1) begin
         errors++; $display("FAIL regrant_after_window got %0d expected 1", active_src);
      end
      touch_1 = 1'b1;
   endtask

   initial begin
      test_reset();
      test_heartbeat();
      test_glitch();
      test_fade_in();
      test_priority();
      test_release_repress();
      test_reset_in_hold();
      cyc(2);
      checks++;
      if (onehot_viol != 0) begin
         errors++; $display("FAIL pwm_onehot got %0d cycles expected 0", onehot_viol);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
